regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_clr_seq.sv | 62 ++++++
 rtl/regfile_mp.sv | 65 ++++++
 tb/tb_regfile_mp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port integer register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  // Address width for a register count; clamps to 1 so a 1-bit address always exists.
  function automatic int rf_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry once after reset or on request, then
// hands the array to the write/read ports.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter  int NREGS = RF_NREGS,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_req,
  output logic          ready,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] clr_idx, idx_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    ready     = 1'b0;
    clr_done  = 1'b0;
    clr_we    = 1'b0;
    case (state)
      RF_CLEAR: begin
        clr_we  = 1'b1;
        idx_nxt = clr_idx + 1'b1;
        if (clr_idx == AW'(NREGS - 1)) begin
          clr_done  = 1'b1;
          state_nxt = RF_RUN;
        end
      end
      RF_RUN: begin
        ready = 1'b1;
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RF_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  assign clr_addr = clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired x0, optional
// write-to-read bypass and a sequential clear engine (array itself is never reset).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = RF_XLEN,
  parameter  int NREGS    = RF_NREGS,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                clr_req,
  output logic                ready,
  output logic                clr_done
);

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          port_we;

  logic [XLEN-1:0] mem [NREGS];

  regfile_clr_seq #(.NREGS(NREGS)) u_clr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .ready    (ready),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign port_we = we && ready && !((ZERO_REG != 0) && (waddr == '0));

  // clr_we and ready are mutually exclusive, so the clear path never races a port write.
  always_ff @(posedge clk) begin
    if (clr_we)       mem[clr_addr] <= '0;
    else if (port_we) mem[waddr]    <= wdata;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = raddr[i*AW +: AW];

    always_comb begin
      rd = mem[ra];
      if (!ready)                                 rd = '0;
      else if ((ZERO_REG != 0) && (ra == '0))     rd = '0;
      else if ((BYPASS != 0) && we && ra == waddr) rd = wdata;
    end

    assign rdata[i*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, a no-bypass build and a wide
// 4-port build share one clock and reset; expectations flow through a scoreboard queue.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // u0: defaults (XLEN=32, NREGS=32, NRD=2, ZERO_REG=1, BYPASS=1)
  logic        we0, clr_req0, ready0, clr_done0;
  logic [4:0]  waddr0;
  logic [31:0] wdata0;
  logic [9:0]  raddr0;
  logic [63:0] rdata0;

  // u1: BYPASS=0
  logic        we1, clr_req1, ready1, clr_done1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic [9:0]  raddr1;
  logic [63:0] rdata1;

  // u2: XLEN=64, NREGS=16, NRD=4
  logic         we2, clr_req2, ready2, clr_done2;
  logic [3:0]   waddr2;
  logic [63:0]  wdata2;
  logic [15:0]  raddr2;
  logic [255:0] rdata2;

  regfile_mp u0 (
    .clk(clk), .reset_n(reset_n), .we(we0), .waddr(waddr0), .wdata(wdata0),
    .raddr(raddr0), .rdata(rdata0), .clr_req(clr_req0), .ready(ready0), .clr_done(clr_done0)
  );

  regfile_mp #(.BYPASS(0)) u1 (
    .clk(clk), .reset_n(reset_n), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .raddr(raddr1), .rdata(rdata1), .clr_req(clr_req1), .ready(ready1), .clr_done(clr_done1)
  );

  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4)) u2 (
    .clk(clk), .reset_n(reset_n), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .raddr(raddr2), .rdata(rdata2), .clr_req(clr_req2), .ready(ready2), .clr_done(clr_done2)
  );

  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic push(input string t, input logic [63:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    we0 = 0; waddr0 = '0; wdata0 = '0; raddr0 = '0; clr_req0 = 0;
    we1 = 0; waddr1 = '0; wdata1 = '0; raddr1 = '0; clr_req1 = 0;
    we2 = 0; waddr2 = '0; wdata2 = '0; raddr2 = '0; clr_req2 = 0;
    repeat (3) tick();

    // Reset state
    push("rst_ready0", 64'(0));    chk(64'(ready0));
    push("rst_clr_done0", 64'(0)); chk(64'(clr_done0));
    push("rst_rdata0", 64'(0));    chk(rdata0);
    push("rst_ready2", 64'(0));    chk(64'(ready2));

    // Clear after reset release: 32 cycles for u0/u1, 16 for u2
    reset_n = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      push("boot_ready0", 64'(c == 33));    chk(64'(ready0));
      push("boot_clr_done0", 64'(c == 32)); chk(64'(clr_done0));
      push("boot_ready1", 64'(c == 33));    chk(64'(ready1));
      push("boot_ready2", 64'(c >= 17));    chk(64'(ready2));
      push("boot_clr_done2", 64'(c == 16)); chk(64'(clr_done2));
      if (c < 33) tick();
    end

    for (int i = 0; i < 32; i++) begin
      raddr0 = {5'(31 - i), 5'(i)};
      #1;
      push("boot_zero_p0", 64'(0)); push("boot_zero_p1", 64'(0));
      chk(64'(rdata0[31:0])); chk(64'(rdata0[63:32]));
    end

    // Write x5, read on both ports
    we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
    push("x5_p0", 64'h0000_0000_DEAD_BEEF); push("x5_p1", 64'h0000_0000_DEAD_BEEF);
    tick();
    we0 = 0; raddr0 = {5'd5, 5'd5};
    #1;
    chk(64'(rdata0[31:0])); chk(64'(rdata0[63:32]));

    // x0 is hardwired, even with a same-cycle bypass candidate
    we0 = 1; waddr0 = 5'd0; wdata0 = 32'h1234; raddr0 = '0;
    #1;
    push("x0_same_cycle", 64'(0)); chk(64'(rdata0[31:0]));
    tick();
    we0 = 0;
    #1;
    push("x0_after_write", 64'(0)); chk(64'(rdata0[31:0]));

    // Same-cycle bypass vs. no bypass
    we0 = 1; waddr0 = 5'd7; wdata0 = 32'hA5A5A5A5; raddr0 = {5'd0, 5'd7};
    we1 = 1; waddr1 = 5'd7; wdata1 = 32'hA5A5A5A5; raddr1 = {5'd0, 5'd7};
    #1;
    push("bypass_on_same", 64'h0000_0000_A5A5_A5A5); chk(64'(rdata0[31:0]));
    push("bypass_off_same", 64'(0));                 chk(64'(rdata1[31:0]));
    push("bypass_off_next", 64'h0000_0000_A5A5_A5A5);
    tick();
    we0 = 0; we1 = 0;
    #1;
    chk(64'(rdata1[31:0]));

    // Fill x1..x31 with nonzero data
    for (int i = 1; i < 32; i++) begin
      we0 = 1; waddr0 = 5'(i); wdata0 = 32'h1000_0000 | 32'(i << 8) | 32'(i);
      tick();
    end
    we0 = 0; raddr0 = {5'd31, 5'd1};
    #1;
    push("fill_x1", 64'h0000_0000_1000_0101);  chk(64'(rdata0[31:0]));
    push("fill_x31", 64'h0000_0000_1000_1F1F); chk(64'(rdata0[63:32]));

    // Clear request with a same-cycle write; later write during CLEAR is dropped
    clr_req0 = 1; we0 = 1; waddr0 = 5'd9; wdata0 = 32'h99;
    tick();
    clr_req0 = 0; we0 = 0;
    for (int c = 1; c <= 33; c++) begin
      push("clr_ready0", 64'(c == 33));    chk(64'(ready0));
      push("clr_clr_done0", 64'(c == 32)); chk(64'(clr_done0));
      if (c == 5) begin
        push("clr_rdata_gated", 64'(0)); chk(64'(rdata0[63:32]));
      end
      if (c == 11) begin we0 = 1; waddr0 = 5'd2; wdata0 = 32'hFFFFFFFF; end
      if (c == 12) we0 = 0;
      if (c < 33) tick();
    end
    for (int i = 0; i < 32; i++) begin
      raddr0 = {5'(31 - i), 5'(i)};
      #1;
      push("clr_zero_p0", 64'(0)); push("clr_zero_p1", 64'(0));
      chk(64'(rdata0[31:0])); chk(64'(rdata0[63:32]));
    end

    // Reset mid-clear at index 10 restarts from 0
    clr_req0 = 1;
    tick();
    clr_req0 = 0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    push("midrst_ready0", 64'(0));    chk(64'(ready0));
    push("midrst_clr_done0", 64'(0)); chk(64'(clr_done0));
    tick();
    reset_n = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      push("restart_ready0", 64'(c == 33));    chk(64'(ready0));
      push("restart_clr_done0", 64'(c == 32)); chk(64'(clr_done0));
      push("restart_ready2", 64'(c >= 17));    chk(64'(ready2));
      if (c < 33) tick();
    end

    // Wide 4-port build
    we2 = 1; waddr2 = 4'd5; wdata2 = 64'hDEADBEEF_CAFEF00D;
    for (int p = 0; p < 4; p++) push("w_x5", 64'hDEADBEEF_CAFEF00D);
    tick();
    we2 = 0; raddr2 = {4'd5, 4'd5, 4'd5, 4'd5};
    #1;
    for (int p = 0; p < 4; p++) chk(rdata2[p*64 +: 64]);

    we2 = 1; waddr2 = 4'd15; wdata2 = 64'h01234567_89ABCDEF;
    raddr2 = {4'd15, 4'd0, 4'd5, 4'd15};
    #1;
    push("w_byp_p0", 64'h01234567_89ABCDEF); chk(rdata2[63:0]);
    push("w_old_p1", 64'hDEADBEEF_CAFEF00D); chk(rdata2[127:64]);
    push("w_zero_p2", 64'(0));               chk(rdata2[191:128]);
    push("w_byp_p3", 64'h01234567_89ABCDEF); chk(rdata2[255:192]);
    tick();
    we2 = 0;
    #1;
    push("w_x15_p0", 64'h01234567_89ABCDEF); chk(rdata2[63:0]);
    push("w_x15_p3", 64'h01234567_89ABCDEF); chk(rdata2[255:192]);

    we2 = 1; waddr2 = 4'd0; wdata2 = '1;
    tick();
    we2 = 0; raddr2 = '0;
    #1;
    push("w_x0", 64'(0)); chk(rdata2[63:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
